// File: rtl/data_mem_resp.sv
// MEM-stage data-memory responder: word reads with fixed latency, 32-bit and
// 64-bit stores (64-bit split into two word writes), Stall back-pressure and Err pulse.
module data_mem_resp #(
    parameter int unsigned AW       = 10,
    parameter int unsigned READ_LAT = 3
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemWrite64,
    input  logic [31:0] Adrs_MEM,
    input  logic [31:0] Rt_data_MEM,
    input  logic [63:0] Rt_data64_MEM,
    output logic [31:0] Read_data,
    output logic        Rd_valid,
    output logic        Stall,
    output logic        Err
);

    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR64_HI = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     hi_q, hi_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;

    logic [DW-1:0]     mem_q [DEPTH];

    logic              any_req_c;
    logic              multi_req_c;
    logic              range_bad_c;
    logic              align_bad_c;
    logic              req_bad_c;
    logic [AW-1:0]     req_idx_c;
    logic              we_c;
    logic [AW-1:0]     widx_c;
    logic [DW-1:0]     wdata_c;

    // Request decode and legality checks, evaluated only when accepting in IDLE
    always_comb begin
        any_req_c   = MemRead | MemWrite | MemWrite64;
        multi_req_c = (MemRead & MemWrite) | (MemRead & MemWrite64) | (MemWrite & MemWrite64);
        range_bad_c = (Adrs_MEM >> (AW + 2)) != 32'd0;
        align_bad_c = MemWrite64 ? (Adrs_MEM[2:0] != 3'd0) : (Adrs_MEM[1:0] != 2'd0);
        req_bad_c   = multi_req_c | range_bad_c | align_bad_c;
        req_idx_c   = Adrs_MEM[AW+1:2];
    end

    // Next-state, datapath and single memory write port
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        hi_d       = hi_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        we_c       = 1'b0;
        widx_c     = req_idx_c;
        wdata_c    = Rt_data_MEM;

        unique case (state_q)
            S_IDLE: begin
                if (any_req_c) begin
                    if (req_bad_c) begin
                        err_d = 1'b1;
                    end else if (MemRead) begin
                        state_d = S_RD_WAIT;
                        cnt_d   = CNT_W'(READ_LAT - 1);
                        idx_d   = req_idx_c;
                    end else if (MemWrite) begin
                        we_c    = 1'b1;
                        wdata_c = Rt_data_MEM;
                    end else begin
                        we_c    = 1'b1;
                        wdata_c = Rt_data64_MEM[31:0];
                        hi_d    = Rt_data64_MEM[63:32];
                        idx_d   = req_idx_c;
                        state_d = S_WR64_HI;
                    end
                end
            end
            S_RD_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rdata_d    = mem_q[idx_q];
                    rd_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_WR64_HI: begin
                we_c    = 1'b1;
                widx_c  = idx_q + AW'(1);
                wdata_c = hi_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            hi_q       <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            hi_q       <= hi_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Storage array is deliberately not reset; writes are suppressed while reset is held
    always_ff @(posedge Clk) begin
        if (we_c && Rst_n) begin
            mem_q[widx_c] <= wdata_c;
        end
    end

    assign Read_data = rdata_q;
    assign Rd_valid  = rd_valid_q;
    assign Err       = err_q;
    assign Stall     = (state_q == S_RD_WAIT) && (cnt_q != '0);

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed vector table, reset corner
// sequences, then randomized traffic against a transaction-level memory model.
module tb_data_mem_resp;

    localparam int RL = 3;
    localparam int AWB = 10;
    localparam logic [2:0] RD  = 3'b100;
    localparam logic [2:0] WR  = 3'b010;
    localparam logic [2:0] W64 = 3'b001;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        MemRead, MemWrite, MemWrite64;
    logic [31:0] Adrs_MEM, Rt_data_MEM;
    logic [63:0] Rt_data64_MEM;
    logic [31:0] Read_data;
    logic        Rd_valid, Stall, Err;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ref_mem [int];
    int          written [$];

    typedef struct {
        logic [2:0]  stb;
        logic [31:0] addr;
        logic [63:0] data;
        bit          hold;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [$];

    data_mem_resp #(.AW(AWB), .READ_LAT(RL)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .MemWrite64    (MemWrite64),
        .Adrs_MEM      (Adrs_MEM),
        .Rt_data_MEM   (Rt_data_MEM),
        .Rt_data64_MEM (Rt_data64_MEM),
        .Read_data     (Read_data),
        .Rd_valid      (Rd_valid),
        .Stall         (Stall),
        .Err           (Err)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Legality straight from the request rules, independent of the DUT structure
    function automatic bit is_bad(input logic [2:0] stb, input logic [31:0] addr);
        int n = int'(stb[0]) + int'(stb[1]) + int'(stb[2]);
        if (n > 1) return 1'b1;
        if (addr >= 32'(4 * (2 ** AWB))) return 1'b1;
        if (stb[0]) return (addr % 8) != 0;
        return (addr % 4) != 0;
    endfunction

    function automatic void mwrite(input int idx, input logic [31:0] v);
        if (!ref_mem.exists(idx)) written.push_back(idx);
        ref_mem[idx] = v;
    endfunction

    function automatic void add(input logic [2:0] stb, input logic [31:0] addr, input logic [63:0] d,
                                input bit hold, input bit err, input logic [31:0] exp);
        vec_t v;
        v.stb = stb; v.addr = addr; v.data = d; v.hold = hold; v.exp_err = err; v.exp_rd = exp;
        tbl.push_back(v);
    endfunction

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead = 1'b0; MemWrite = 1'b0; MemWrite64 = 1'b0;
    endtask

    // Drive one request and check the whole transaction timing
    task automatic do_txn(input logic [2:0] stb, input logic [31:0] addr, input logic [63:0] d,
                          input bit hold, input bit exp_err, input logic [31:0] exp_rd);
        MemRead = stb[2]; MemWrite = stb[1]; MemWrite64 = stb[0];
        Adrs_MEM      = addr;
        Rt_data_MEM   = stb[0] ? ~d[31:0] : d[31:0];
        Rt_data64_MEM = stb[1] ? ~d : d;
        cyc();
        if (exp_err) begin
            chk1("err_pulse", Err, 1'b1);
            chk1("err_no_rdvalid", Rd_valid, 1'b0);
            chk1("err_no_stall", Stall, 1'b0);
            idle_inputs();
            cyc();
            chk1("err_one_cycle", Err, 1'b0);
            chk1("err_no_late_rdvalid", Rd_valid, 1'b0);
        end else if (stb[2]) begin
            if (!hold) idle_inputs();
            for (int c = 0; c < RL; c++) begin
                chk1("rd_stall", Stall, c < RL - 1);
                chk1("rd_early_valid", Rd_valid, 1'b0);
                if (c == RL - 1) idle_inputs();
                cyc();
            end
            chk1("rd_valid", Rd_valid, 1'b1);
            chk32("rd_data", Read_data, exp_rd);
            chk1("rd_stall_done", Stall, 1'b0);
            chk1("rd_no_err", Err, 1'b0);
            cyc();
            chk1("rd_valid_single", Rd_valid, 1'b0);
            chk32("rd_data_hold", Read_data, exp_rd);
        end else if (stb[1]) begin
            idle_inputs();
            chk1("wr_no_stall", Stall, 1'b0);
            chk1("wr_no_err", Err, 1'b0);
            mwrite(int'(addr >> 2), d[31:0]);
        end else begin
            chk1("wr64_no_stall", Stall, 1'b0);
            chk1("wr64_no_err", Err, 1'b0);
            cyc();
            idle_inputs();
            chk1("wr64_hi_no_stall", Stall, 1'b0);
            chk1("wr64_no_rdvalid", Rd_valid, 1'b0);
            mwrite(int'(addr >> 2), d[31:0]);
            mwrite(int'(addr >> 2) + 1, d[63:32]);
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        idle_inputs();
        Adrs_MEM = '0; Rt_data_MEM = '0; Rt_data64_MEM = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk32("reset_read_data", Read_data, 32'h0);
        chk1("reset_rd_valid", Rd_valid, 1'b0);
        chk1("reset_stall", Stall, 1'b0);
        chk1("reset_err", Err, 1'b0);
        Rst_n = 1'b1;
        cyc();

        add(WR,       32'h10,   64'h0000_0000_DEAD_BEEF, 0, 0, 32'h0);
        add(RD,       32'h10,   64'h0,                   0, 0, 32'hDEAD_BEEF);
        add(W64,      32'h20,   64'h1122_3344_5566_7788, 0, 0, 32'h0);
        add(RD,       32'h20,   64'h0,                   0, 0, 32'h5566_7788);
        add(RD,       32'h24,   64'h0,                   0, 0, 32'h1122_3344);
        add(RD,       32'h13,   64'h0,                   0, 1, 32'h0);
        add(W64,      32'h24,   64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 32'h0);
        add(RD,       32'h1000, 64'h0,                   0, 1, 32'h0);
        add(RD | WR,  32'h10,   64'h0,                   0, 1, 32'h0);
        add(WR,       32'h1010, 64'h0,                   0, 1, 32'h0);
        add(RD|WR|W64,32'h20,   64'h0,                   0, 1, 32'h0);
        add(WR,       32'h12,   64'h0,                   0, 1, 32'h0);
        add(RD,       32'h24,   64'h0,                   0, 0, 32'h1122_3344);
        add(RD,       32'h10,   64'h0,                   1, 0, 32'hDEAD_BEEF);
        add(WR,       32'hFFC,  64'h0000_0000_CAFE_F00D, 0, 0, 32'h0);
        add(RD,       32'hFFC,  64'h0,                   1, 0, 32'hCAFE_F00D);
        add(W64,      32'hFF8,  64'h0BAD_F00D_600D_CAFE, 0, 0, 32'h0);
        add(RD,       32'hFF8,  64'h0,                   0, 0, 32'h600D_CAFE);
        add(RD,       32'hFFC,  64'h0,                   0, 0, 32'h0BAD_F00D);
        add(RD,       32'h20,   64'h0,                   0, 0, 32'h5566_7788);

        foreach (tbl[i])
            do_txn(tbl[i].stb, tbl[i].addr, tbl[i].data, tbl[i].hold, tbl[i].exp_err, tbl[i].exp_rd);

        // Reset while a read is outstanding with one stall cycle left
        MemRead = 1'b1; Adrs_MEM = 32'h10;
        cyc();
        idle_inputs();
        cyc();
        chk1("abort_pre_stall", Stall, 1'b1);
        Rst_n = 1'b0;
        #1;
        chk1("abort_stall_drop", Stall, 1'b0);
        chk1("abort_rdvalid", Rd_valid, 1'b0);
        chk32("abort_read_data", Read_data, 32'h0);
        repeat (2) begin
            cyc();
            chk1("abort_no_rdvalid", Rd_valid, 1'b0);
        end
        Rst_n = 1'b1;
        repeat (2) begin
            cyc();
            chk1("abort_post_no_rdvalid", Rd_valid, 1'b0);
            chk1("abort_post_no_stall", Stall, 1'b0);
        end
        do_txn(RD, 32'h20, 64'h0, 0, 0, 32'h5566_7788);

        // Reset while the high half of a 64-bit store is pending
        do_txn(WR, 32'h30, 64'h0000_0000_AAAA_0000, 0, 0, 32'h0);
        do_txn(WR, 32'h34, 64'h0000_0000_BBBB_1111, 0, 0, 32'h0);
        MemWrite64 = 1'b1; Adrs_MEM = 32'h30;
        Rt_data64_MEM = 64'h1234_5678_9ABC_DEF0; Rt_data_MEM = 32'h0;
        cyc();
        idle_inputs();
        Rst_n = 1'b0;
        #1;
        chk1("wr64_abort_stall", Stall, 1'b0);
        cyc();
        Rst_n = 1'b1;
        cyc();
        mwrite(12, 32'h9ABC_DEF0);
        do_txn(RD, 32'h30, 64'h0, 0, 0, 32'h9ABC_DEF0);
        do_txn(RD, 32'h34, 64'h0, 0, 0, 32'hBBBB_1111);

        // Randomized traffic against the word-array model
        for (int n = 0; n < 300; n++) begin
            int r   = int'($urandom_range(0, 9));
            int idx = int'($urandom_range(0, 1023));
            logic [63:0] d = {$urandom, $urandom};
            if (r < 4) begin
                do_txn(WR, 32'(idx * 4), d, 0, 0, 32'h0);
            end else if (r < 6) begin
                idx = int'($urandom_range(0, 511)) * 2;
                do_txn(W64, 32'(idx * 4), d, 0, 0, 32'h0);
            end else if (r < 9) begin
                idx = written[$urandom_range(0, written.size() - 1)];
                do_txn(RD, 32'(idx * 4), 64'h0, bit'($urandom_range(0, 1)), 0, ref_mem[idx]);
            end else begin
                logic [2:0]  stb;
                logic [31:0] addr;
                int k = int'($urandom_range(0, 3));
                stb  = RD;
                addr = 32'(idx * 4);
                case (k)
                    0: begin
                        stb = 3'($urandom_range(3, 7));
                        if (stb == 3'b100) stb = 3'b101;
                    end
                    1: addr = addr + 32'($urandom_range(1, 3));
                    2: begin
                        stb  = W64;
                        addr = 32'((idx | 1) * 4);
                    end
                    default: begin
                        stb  = (idx % 2 == 0) ? WR : RD;
                        addr = addr | (32'd1 << $urandom_range(12, 31));
                    end
                endcase
                do_txn(stb, addr, d, 0, is_bad(stb, addr), 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- MEM-stage data-memory responder.
- Consumes the MemRead / MemWrite / MemWrite64 strobes, byte address and store data driven out of the EXE/MEM pipeline register.
- Services word reads with configurable latency, plus 32-bit and 64-bit stores. A 64-bit store is split into two word writes.
- Returns read data and a Stall back-pressure signal that freezes the upstream pipeline registers while a read is outstanding.

Parameters:
- AW, 10, word-address width; memory holds 2**AW 32-bit words.
- READ_LAT, 3, read latency in clock edges from accept to data capture; legal range 1..15.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- MemRead  input  1  word read request (level).
- MemWrite  input  1  32-bit store request (level).
- MemWrite64  input  1  64-bit store request (level).
- Adrs_MEM  input  32  byte address.
- Rt_data_MEM  input  32  32-bit store data.
- Rt_data64_MEM  input  64  64-bit store data; [31:0] goes to the low word, [63:32] to the high word.
- Read_data  output  32  registered read data.
- Rd_valid  output  1  one-cycle pulse; Read_data is valid.
- Stall  output  1  upstream must hold its pipeline registers.
- Err  output  1  one-cycle pulse; request rejected, no access performed.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - State = IDLE, counter = 0.
  - Read_data = 0, Rd_valid = 0, Err = 0.
  - Stall = 0, since it is decoded from state.
  - Memory array contents are not reset.
- States:
  - IDLE: requests are sampled only in this state.
  - RD_WAIT: read outstanding.
  - WR64_HI: high word of a 64-bit store pending.
- Accept (rising edge in IDLE):
  - If exactly one strobe is high, latch the address, data and operation.
  - If no strobe is high, stay IDLE.
  - Word index = Adrs_MEM[AW+1:2].
- Error checks (at accept; any failure -> Err = 1 for the next cycle, state stays IDLE, memory untouched):
  - More than one strobe high.
  - Adrs_MEM[31:AW+2] nonzero.
  - Adrs_MEM[1:0] nonzero for MemRead or MemWrite.
  - Adrs_MEM[2:0] nonzero for MemWrite64.
- MemWrite: mem[idx] <= Rt_data_MEM at the accept edge; stay IDLE; no stall.
- MemWrite64:
  - Accept edge: mem[idx] <= Rt_data64_MEM[31:0]; go to WR64_HI.
  - Next edge: mem[idx+1] <= latched [63:32]; go to IDLE.
  - Inputs presented during WR64_HI are ignored, so the still-held request is not re-accepted.
  - No stall.
- MemRead:
  - Accept edge at t: go to RD_WAIT, counter = READ_LAT-1.
  - Each edge in RD_WAIT with counter != 0: counter decrements.
  - Edge with counter == 0: Read_data <= mem[idx], Rd_valid = 1 for the following cycle, go to IDLE.
  - Data is therefore captured at edge t+READ_LAT.
- Stall = (state == RD_WAIT) && (counter != 0), combinational from registers.
  - A read stalls upstream for exactly READ_LAT-1 cycles.
  - Stall is low in the completion cycle, so the pipeline advances on the same edge that captures the data.
- Requests present while not IDLE are ignored; they are never queued.
- Read_data holds its value until the next read completes.
- Rd_valid and Err are never both high.
- Reset mid-operation:
  - During RD_WAIT: the read is aborted, Rd_valid is never pulsed.
  - During WR64_HI: the high word is not written; the low word stays written.
- Read after write to the same word returns the new value; no bypass is needed, since the write completes before the next accept.

Test Plan:
- Reset, then MemWrite to addr 0x10 with data 0xDEADBEEF, then MemRead 0x10 (READ_LAT=3) -> Stall high 2 cycles, Read_data=0xDEADBEEF with Rd_valid exactly 3 edges after accept, Stall low that cycle.
- MemWrite64 to addr 0x20 with 0x11223344_55667788, then read 0x20 and 0x24 -> 0x55667788 and 0x11223344; Stall never asserted during the store.
- MemRead at 0x13 (misaligned), MemWrite64 at 0x24 (not 8-aligned), MemRead at 0x1000 (out of range for AW=10), MemRead and MemWrite together -> Err pulse for each, no Rd_valid, memory unchanged.
- Hold MemRead at 0x10 through its whole stall window -> exactly one Rd_valid pulse per accept, no duplicate read while busy.
- Assert Rst_n low mid-RD_WAIT (counter=1) -> Stall and Rd_valid drop immediately, Read_data=0; after release, a new read completes normally.
- Assert Rst_n low while in WR64_HI -> mem[idx] holds the new low word, mem[idx+1] holds the old value.
